dfi_phy_model: RTL
==================

DFI_PHY_MODEL -- requirements
Module: dfi_phy_model

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 15, DFI address width.
REQ-002 SHALL have parameter BANK_WIDTH, default 3, DFI bank width.
REQ-003 SHALL have parameter DQ_WIDTH, default 64; one data beat word is 4*DQ_WIDTH bits.
REQ-004 SHALL have parameter RD_LAT, default 4, range 1..15: clk cycles from dfi_rddata_en to dfi_rddata_valid.
REQ-005 SHALL have parameter MEM_AW, default 6, MEM_AW > BANK_WIDTH: storage has 2^MEM_AW words.
REQ-006 SHALL have parameter INIT_CYCLES, default 16, range 1..255.
REQ-007 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-008 SHALL have ports dfi_address0/1 in ROW_WIDTH; dfi_bank0/1 in BANK_WIDTH; dfi_cs_n0/1, dfi_ras_n0/1, dfi_cas_n0/1, dfi_we_n0/1 in 1 each: slot 0/1 command.
REQ-009 SHALL have ports dfi_wrdata_en in 1; dfi_wrdata in 4*DQ_WIDTH; dfi_wrdata_mask in 4*DQ_WIDTH/8 (1 = byte not written).
REQ-010 SHALL have ports dfi_rddata_en in 1; dfi_rddata out 4*DQ_WIDTH; dfi_rddata_valid out 1.
REQ-011 SHALL have ports dfi_init_complete out 1; act_cnt, wr_cnt, rd_cnt out 16 each; cmd_err out 1 (sticky).

Function
REQ-012 Decode per slot when cs_n=0, {ras_n,cas_n,we_n}: 011 ACT, 010 PRE, 101 RD, 100 WR, 001 REF, 000 MRS, 111 NOP; cs_n=1 is NOP.
REQ-013 Slot 0 SHALL be processed before slot 1 within a cycle; slot 1 sees slot 0's bank-state update.
REQ-014 Per bank: open bit + open row. ACT sets open, records address; ACT to open bank sets cmd_err, updates row.
REQ-015 PRE with address[10]=1 closes all banks; else closes dfi_bank only; PRE to closed bank is legal.
REQ-016 REF with any bank open SHALL set cmd_err; REF/MRS otherwise no state change.
REQ-017 RD/WR to closed bank SHALL set cmd_err and still be queued.
REQ-018 Word index = {bank, address[MEM_AW-BANK_WIDTH+2:3]}; row ignored (aliasing intended).
REQ-019 WR pushes index into 4-deep write-address FIFO; RD into 4-deep read-address FIFO; push when full drops the entry, sets cmd_err.
REQ-020 dfi_wrdata_en=1: pop write FIFO, write dfi_wrdata into word, byte lanes with mask=0 only; empty FIFO: no write, cmd_err.
REQ-021 dfi_rddata_en=1: pop read FIFO, read word, launch RD_LAT-stage pipeline; empty FIFO: returns zeros, cmd_err.
REQ-022 dfi_rddata_valid SHALL assert exactly RD_LAT cycles after each dfi_rddata_en, one cycle per beat, back-to-back supported.
REQ-023 Write and read pop same cycle, same index: read SHALL return the new (post-mask) data.
REQ-024 Push and pop same cycle on a FIFO: both take effect; full FIFO with simultaneous pop is not overflow.
REQ-025 Two WRs (slot 0 and 1) in one cycle SHALL push in slot order; two pushes count separately toward full.
REQ-026 act_cnt/wr_cnt/rd_cnt increment per decoded command (up to 2/cycle), wrap at 2^16.
REQ-027 Commands before dfi_init_complete=1 SHALL be ignored except setting cmd_err.

Reset
REQ-028 rst: dfi_init_complete=0, dfi_rddata_valid=0, dfi_rddata=0, counters=0, cmd_err=0, all banks closed, FIFOs empty, read pipeline flushed.
REQ-029 dfi_init_complete SHALL assert INIT_CYCLES cycles after first cycle with rst=0, stay 1 until rst.
REQ-030 Storage contents SHALL NOT be cleared by rst.
REQ-031 rst mid-read SHALL drop in-flight beats: no dfi_rddata_valid after rst.

Verification
REQ-032 Release rst -> dfi_init_complete=1 exactly 16 cycles later; command at cycle 10 -> cmd_err=1.
REQ-033 ACT b2, WR b2 col 0x08, wrdata_en with 0xA5.. all-lanes, RD b2 col 0x08, rddata_en -> valid 4 cycles later, data 0xA5.., cmd_err=0, act/wr/rd_cnt=1.
REQ-034 Partial write mask 0x...FE over 0xA5.. with 0x11.. -> read returns 0xA5.. except byte 0 = 0x11.
REQ-035 RD to closed bank 5 -> cmd_err=1, read still queued and returned.
REQ-036 Five RDs without rddata_en -> fifth dropped, cmd_err=1; four rddata_en back-to-back -> four consecutive valid cycles.
REQ-037 rst asserted 2 cycles after rddata_en -> no dfi_rddata_valid; outputs at reset values.

Source files
------------

// File: rtl/dfi_phy_model_if.sv
// DFI bundle between a memory controller (master) and the PHY model (slave):
// two command slots, write data path, read data path and init status.
interface dfi_phy_model_if #(
  parameter int ROW_WIDTH  = 15,
  parameter int BANK_WIDTH = 3,
  parameter int DQ_WIDTH   = 64
);
  logic [ROW_WIDTH-1:0]      dfi_address0, dfi_address1;
  logic [BANK_WIDTH-1:0]     dfi_bank0, dfi_bank1;
  logic                      dfi_cs_n0, dfi_cs_n1;
  logic                      dfi_ras_n0, dfi_ras_n1;
  logic                      dfi_cas_n0, dfi_cas_n1;
  logic                      dfi_we_n0, dfi_we_n1;
  logic                      dfi_wrdata_en;
  logic [4*DQ_WIDTH-1:0]     dfi_wrdata;
  logic [4*DQ_WIDTH/8-1:0]   dfi_wrdata_mask;
  logic                      dfi_rddata_en;
  logic [4*DQ_WIDTH-1:0]     dfi_rddata;
  logic                      dfi_rddata_valid;
  logic                      dfi_init_complete;

  modport master (
    output dfi_address0, dfi_address1, dfi_bank0, dfi_bank1,
           dfi_cs_n0, dfi_cs_n1, dfi_ras_n0, dfi_ras_n1,
           dfi_cas_n0, dfi_cas_n1, dfi_we_n0, dfi_we_n1,
           dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
    input  dfi_rddata, dfi_rddata_valid, dfi_init_complete
  );

  modport slave (
    input  dfi_address0, dfi_address1, dfi_bank0, dfi_bank1,
           dfi_cs_n0, dfi_cs_n1, dfi_ras_n0, dfi_ras_n1,
           dfi_cas_n0, dfi_cas_n1, dfi_we_n0, dfi_we_n1,
           dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
    output dfi_rddata, dfi_rddata_valid, dfi_init_complete
  );
endinterface

// File: rtl/dfi_phy_model.sv
// Behavioural DFI PHY: decodes two command slots per cycle, tracks bank state,
// queues RD/WR word indices and serves data through a fixed RD_LAT read pipe.
module dfi_phy_model #(
  parameter int ROW_WIDTH   = 15,
  parameter int BANK_WIDTH  = 3,
  parameter int DQ_WIDTH    = 64,
  parameter int RD_LAT      = 4,
  parameter int MEM_AW      = 6,
  parameter int INIT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dfi_phy_model_if.slave       dfi,
  output logic [15:0]          act_cnt,
  output logic [15:0]          wr_cnt,
  output logic [15:0]          rd_cnt,
  output logic                 cmd_err
);
  localparam int NB = 1 << BANK_WIDTH;
  localparam int NW = 1 << MEM_AW;
  localparam int DW = 4 * DQ_WIDTH;
  localparam int BW = DW / 8;

  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR, CMD_REF, CMD_MRS} cmd_e;

  function automatic cmd_e decode(input logic cs_n, input logic [2:0] rcw);
    cmd_e c;
    c = CMD_NOP;
    if (!cs_n) begin
      case (rcw)
        3'b011:  c = CMD_ACT;
        3'b010:  c = CMD_PRE;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b001:  c = CMD_REF;
        3'b000:  c = CMD_MRS;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

  logic [ROW_WIDTH-1:0]  s_addr [2];
  logic [BANK_WIDTH-1:0] s_bank [2];
  logic [MEM_AW-1:0]     s_idx  [2];
  cmd_e                  s_cmd  [2];

  assign s_addr[0] = dfi.dfi_address0;
  assign s_addr[1] = dfi.dfi_address1;
  assign s_bank[0] = dfi.dfi_bank0;
  assign s_bank[1] = dfi.dfi_bank1;
  assign s_cmd[0]  = decode(dfi.dfi_cs_n0, {dfi.dfi_ras_n0, dfi.dfi_cas_n0, dfi.dfi_we_n0});
  assign s_cmd[1]  = decode(dfi.dfi_cs_n1, {dfi.dfi_ras_n1, dfi.dfi_cas_n1, dfi.dfi_we_n1});
  // Row bits are deliberately ignored: every row of a bank aliases the same words.
  assign s_idx[0]  = {s_bank[0], s_addr[0][MEM_AW-BANK_WIDTH+2:3]};
  assign s_idx[1]  = {s_bank[1], s_addr[1][MEM_AW-BANK_WIDTH+2:3]};

  logic                 init_done_q, init_done_d;
  logic [7:0]           init_cnt_q, init_cnt_d;
  logic [NB-1:0]        open_q, open_d;
  logic [ROW_WIDTH-1:0] row_q [NB];
  logic [ROW_WIDTH-1:0] row_d [NB];
  logic [MEM_AW-1:0]    wq_q [4];
  logic [MEM_AW-1:0]    wq_d [4];
  logic [MEM_AW-1:0]    rq_q [4];
  logic [MEM_AW-1:0]    rq_d [4];
  logic [1:0]           wq_wp_q, wq_wp_d, wq_rp_q, wq_rp_d;
  logic [1:0]           rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
  logic [2:0]           wq_cnt_q, wq_cnt_d, rq_cnt_q, rq_cnt_d;
  logic [15:0]          act_cnt_q, act_cnt_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [RD_LAT-1:0]    pipe_vld_q, pipe_vld_d;
  logic [DW-1:0]        pipe_dat_q [RD_LAT];
  logic [DW-1:0]        pipe_dat_d [RD_LAT];

  logic [DW-1:0]        mem_q [NW];
  logic                 mem_we;
  logic [MEM_AW-1:0]    mem_widx;
  logic [DW-1:0]        mem_wdat;
  logic [MEM_AW-1:0]    rd_idx;
  logic                 rd_launch;
  logic [DW-1:0]        rd_word;

  always_comb begin
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    open_d      = open_q;
    row_d       = row_q;
    wq_d        = wq_q;
    rq_d        = rq_q;
    wq_wp_d     = wq_wp_q;
    wq_rp_d     = wq_rp_q;
    wq_cnt_d    = wq_cnt_q;
    rq_wp_d     = rq_wp_q;
    rq_rp_d     = rq_rp_q;
    rq_cnt_d    = rq_cnt_q;
    act_cnt_d   = act_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    cmd_err_d   = cmd_err_q;
    mem_we      = 1'b0;
    mem_widx    = '0;
    mem_wdat    = '0;
    rd_idx      = '0;
    rd_launch   = 1'b0;
    rd_word     = '0;

    if (!init_done_q) begin
      init_cnt_d = init_cnt_q + 8'd1;
      if (init_cnt_q + 8'd1 == 8'(INIT_CYCLES)) init_done_d = 1'b1;
      if (s_cmd[0] != CMD_NOP || s_cmd[1] != CMD_NOP || dfi.dfi_wrdata_en || dfi.dfi_rddata_en)
        cmd_err_d = 1'b1;
    end else begin
      // Pops are taken before this cycle's pushes, so a full FIFO that is also
      // popped still accepts one new entry.
      if (dfi.dfi_wrdata_en) begin
        if (wq_cnt_q != 3'd0) begin
          mem_we   = 1'b1;
          mem_widx = wq_q[wq_rp_q];
          mem_wdat = mem_q[wq_q[wq_rp_q]];
          for (int b = 0; b < BW; b++)
            if (!dfi.dfi_wrdata_mask[b]) mem_wdat[b*8 +: 8] = dfi.dfi_wrdata[b*8 +: 8];
          wq_rp_d  = wq_rp_q + 2'd1;
          wq_cnt_d = wq_cnt_q - 3'd1;
        end else begin
          cmd_err_d = 1'b1;
        end
      end

      if (dfi.dfi_rddata_en) begin
        rd_launch = 1'b1;
        if (rq_cnt_q != 3'd0) begin
          rd_idx   = rq_q[rq_rp_q];
          rd_word  = (mem_we && mem_widx == rd_idx) ? mem_wdat : mem_q[rd_idx];
          rq_rp_d  = rq_rp_q + 2'd1;
          rq_cnt_d = rq_cnt_q - 3'd1;
        end else begin
          cmd_err_d = 1'b1;
        end
      end

      // Slot 1 works on the state already updated by slot 0.
      for (int s = 0; s < 2; s++) begin
        case (s_cmd[s])
          CMD_ACT: begin
            act_cnt_d = act_cnt_d + 16'd1;
            if (open_d[s_bank[s]]) cmd_err_d = 1'b1;
            open_d[s_bank[s]] = 1'b1;
            row_d[s_bank[s]]  = s_addr[s];
          end
          CMD_PRE: begin
            if (s_addr[s][10]) open_d = '0;
            else               open_d[s_bank[s]] = 1'b0;
          end
          CMD_REF: begin
            if (|open_d) cmd_err_d = 1'b1;
          end
          CMD_RD: begin
            rd_cnt_d = rd_cnt_d + 16'd1;
            if (!open_d[s_bank[s]]) cmd_err_d = 1'b1;
            if (rq_cnt_d == 3'd4) begin
              cmd_err_d = 1'b1;
            end else begin
              rq_d[rq_wp_d] = s_idx[s];
              rq_wp_d       = rq_wp_d + 2'd1;
              rq_cnt_d      = rq_cnt_d + 3'd1;
            end
          end
          CMD_WR: begin
            wr_cnt_d = wr_cnt_d + 16'd1;
            if (!open_d[s_bank[s]]) cmd_err_d = 1'b1;
            if (wq_cnt_d == 3'd4) begin
              cmd_err_d = 1'b1;
            end else begin
              wq_d[wq_wp_d] = s_idx[s];
              wq_wp_d       = wq_wp_d + 2'd1;
              wq_cnt_d      = wq_cnt_d + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end

    pipe_vld_d    = pipe_vld_q;
    pipe_dat_d    = pipe_dat_q;
    pipe_vld_d[0] = rd_launch;
    pipe_dat_d[0] = rd_word;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_dat_d[i] = pipe_dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_done_q <= 1'b0;
      init_cnt_q  <= '0;
      open_q      <= '0;
      wq_wp_q     <= '0;
      wq_rp_q     <= '0;
      wq_cnt_q    <= '0;
      rq_wp_q     <= '0;
      rq_rp_q     <= '0;
      rq_cnt_q    <= '0;
      act_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      cmd_err_q   <= 1'b0;
      pipe_vld_q  <= '0;
      for (int i = 0; i < NB; i++) row_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        wq_q[i] <= '0;
        rq_q[i] <= '0;
      end
      for (int i = 0; i < RD_LAT; i++) pipe_dat_q[i] <= '0;
    end else begin
      init_done_q <= init_done_d;
      init_cnt_q  <= init_cnt_d;
      open_q      <= open_d;
      row_q       <= row_d;
      wq_q        <= wq_d;
      rq_q        <= rq_d;
      wq_wp_q     <= wq_wp_d;
      wq_rp_q     <= wq_rp_d;
      wq_cnt_q    <= wq_cnt_d;
      rq_wp_q     <= rq_wp_d;
      rq_rp_q     <= rq_rp_d;
      rq_cnt_q    <= rq_cnt_d;
      act_cnt_q   <= act_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      cmd_err_q   <= cmd_err_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_dat_q  <= pipe_dat_d;
    end
  end

  // Storage survives reset so data written before a reset can still be read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdat;
  end

  assign dfi.dfi_rddata_valid  = pipe_vld_q[RD_LAT-1];
  assign dfi.dfi_rddata        = pipe_dat_q[RD_LAT-1];
  assign dfi.dfi_init_complete = init_done_q;
  assign act_cnt               = act_cnt_q;
  assign wr_cnt                = wr_cnt_q;
  assign rd_cnt                = rd_cnt_q;
  assign cmd_err               = cmd_err_q;
endmodule
